top_level_module: RTL and testbench

Multi-core matrix-multiply top level: up to four identical sequencer cores jointly compute C = A × B. A is a fixed 3×4 operand matrix and B a fixed 4×3 operand matrix, both held in a shared read-only operand store. Output elements are interleaved across the active cores. Each core exposes its 6-bit program counter and a sticky completion flag; results land in a shared 9-entry result register file that the bench inspects hierarchically.

---
 rtl/top_level_module.sv | 126 ++++++++++++
 tb/tb_top_level_module.sv | 127 ++++++++++++
 2 files changed

// File: rtl/top_level_module.sv
// Multi-core matrix multiply: up to four sequencer cores compute C = A x B,
// interleaving the nine output elements across the active cores.
module top_level_module #(
    parameter int ACTIVE_CORES = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic       End_core0,
    output logic       End_core1,
    output logic       End_core2,
    output logic       End_core3,
    output logic [5:0] PC0_out,
    output logic [5:0] PC1_out,
    output logic [5:0] PC2_out,
    output logic [5:0] PC3_out
);

    localparam logic [3:0] STRIDE = 4'(ACTIVE_CORES);

    logic [15:0] res [0:8];

    logic [5:0]  pc_q     [4];
    logic        done_q   [4];
    logic        store_en [4];
    logic [3:0]  store_e  [4];
    logic [15:0] store_v  [4];

    function automatic logic [1:0] row_of(input logic [3:0] e);
        if (e < 4'd3)
            return 2'd0;
        else if (e < 4'd6)
            return 2'd1;
        else
            return 2'd2;
    endfunction

    function automatic logic [1:0] col_of(input logic [3:0] e);
        logic [3:0] c;
        c = e - 4'(3 * row_of(e));
        return c[1:0];
    endfunction

    // Operand store: A[r][k] = 4r+k+1, B[k][c] = 3k+c+1
    function automatic logic [7:0] a_op(input logic [1:0] r, input logic [1:0] k);
        return 8'({r, 2'b00}) + 8'(k) + 8'd1;
    endfunction

    function automatic logic [7:0] b_op(input logic [1:0] k, input logic [1:0] c);
        return 8'(3 * k) + 8'(c) + 8'd1;
    endfunction

    for (genvar K = 0; K < 4; K++) begin : g_core
        localparam bit IDLE = (K >= ACTIVE_CORES);

        logic [1:0]  step;
        logic        st;
        logic [15:0] acc;
        logic [3:0]  elem;
        logic        done;
        logic [5:0]  pc;
        logic [15:0] prod;
        logic [15:0] acc_nxt;

        always_comb begin
            prod    = 16'(a_op(row_of(elem), step)) * 16'(b_op(step, col_of(elem)));
            acc_nxt = (step == 2'd0 ? 16'd0 : acc) + prod;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                step <= 2'd0;
                st   <= 1'b0;
                acc  <= 16'd0;
                elem <= 4'(K);
                done <= 1'b0;
                pc   <= 6'd0;
            end else if (!done) begin
                if (IDLE) begin
                    done <= 1'b1;
                end else begin
                    pc <= pc + 6'd1;
                    if (st) begin
                        st   <= 1'b0;
                        step <= 2'd0;
                        elem <= elem + STRIDE;
                        if (elem + STRIDE > 4'd8)
                            done <= 1'b1;
                    end else begin
                        acc  <= acc_nxt;
                        step <= step + 2'd1;
                        if (step == 2'd3)
                            st <= 1'b1;
                    end
                end
            end
        end

        assign pc_q[K]     = pc;
        assign done_q[K]   = done;
        assign store_en[K] = !IDLE && !done && st;
        assign store_e[K]  = elem;
        assign store_v[K]  = acc;
    end

    // Cores own disjoint elements, so per-core writes never collide
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++)
                res[i] <= 16'd0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (store_en[k])
                    res[store_e[k]] <= store_v[k];
        end
    end

    assign PC0_out   = pc_q[0];
    assign PC1_out   = pc_q[1];
    assign PC2_out   = pc_q[2];
    assign PC3_out   = pc_q[3];
    assign End_core0 = done_q[0];
    assign End_core1 = done_q[1];
    assign End_core2 = done_q[2];
    assign End_core3 = done_q[3];

endmodule

// File: tb/tb_top_level_module.sv
// Directed bench for top_level_module: 4-, 1- and 2-core instances run
// side by side against a per-edge PC/End model and hand-computed C.
module tb_top_level_module;

    logic clk = 1'b0;
    logic rst;

    logic [5:0] pc_a  [3][4];
    logic       end_a [3][4];

    int total = 0;
    int bad   = 0;

    int ns [3] = '{4, 1, 2};
    int c_exp [9] = '{70, 80, 90, 158, 184, 210, 246, 288, 330};

    always #5 clk = ~clk;

    top_level_module #(.ACTIVE_CORES(4)) u4 (
        .clk(clk), .rst(rst),
        .End_core0(end_a[0][0]), .End_core1(end_a[0][1]),
        .End_core2(end_a[0][2]), .End_core3(end_a[0][3]),
        .PC0_out(pc_a[0][0]), .PC1_out(pc_a[0][1]),
        .PC2_out(pc_a[0][2]), .PC3_out(pc_a[0][3])
    );

    top_level_module #(.ACTIVE_CORES(1)) u1 (
        .clk(clk), .rst(rst),
        .End_core0(end_a[1][0]), .End_core1(end_a[1][1]),
        .End_core2(end_a[1][2]), .End_core3(end_a[1][3]),
        .PC0_out(pc_a[1][0]), .PC1_out(pc_a[1][1]),
        .PC2_out(pc_a[1][2]), .PC3_out(pc_a[1][3])
    );

    top_level_module #(.ACTIVE_CORES(2)) u2 (
        .clk(clk), .rst(rst),
        .End_core0(end_a[2][0]), .End_core1(end_a[2][1]),
        .End_core2(end_a[2][2]), .End_core3(end_a[2][3]),
        .PC0_out(pc_a[2][0]), .PC1_out(pc_a[2][1]),
        .PC2_out(pc_a[2][2]), .PC3_out(pc_a[2][3])
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int res_of(input int x, input int e);
        if (x == 0)
            return int'(u4.res[e]);
        else if (x == 1)
            return int'(u1.res[e]);
        else
            return int'(u2.res[e]);
    endfunction

    task automatic check_zero(input string ph);
        for (int x = 0; x < 3; x++) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("%s pc i%0d c%0d", ph, x, k), int'(pc_a[x][k]), 0);
                check($sformatf("%s end i%0d c%0d", ph, x, k), int'(end_a[x][k]), 0);
            end
            for (int e = 0; e < 9; e++)
                check($sformatf("%s res i%0d e%0d", ph, x, e), res_of(x, e), 0);
        end
    endtask

    // Runs edges 1..nmax after reset release, checking every core each edge
    task automatic run(input string ph, input int nmax);
        int m, mmax, epc, eend;
        for (int n = 1; n <= nmax; n++) begin
            @(negedge clk);
            for (int x = 0; x < 3; x++) begin
                for (int k = 0; k < 4; k++) begin
                    if (k >= ns[x]) begin
                        epc  = 0;
                        eend = 1;
                    end else begin
                        m    = (9 - k + ns[x] - 1) / ns[x];
                        epc  = (n < 5 * m) ? n : 5 * m;
                        eend = (n >= 5 * m) ? 1 : 0;
                    end
                    check($sformatf("%s n%0d pc i%0d c%0d", ph, n, x, k),
                          int'(pc_a[x][k]), epc);
                    check($sformatf("%s n%0d end i%0d c%0d", ph, n, x, k),
                          int'(end_a[x][k]), eend);
                end
            end
            if (n == 5) begin
                for (int e = 0; e < 9; e++)
                    check($sformatf("%s n5 res4 e%0d", ph, e), res_of(0, e),
                          (e < 4) ? c_exp[e] : 0);
            end
        end
        for (int x = 0; x < 3; x++) begin
            mmax = (9 + ns[x] - 1) / ns[x];
            if (nmax >= 5 * mmax)
                for (int e = 0; e < 9; e++)
                    check($sformatf("%s C i%0d e%0d", ph, x, e), res_of(x, e), c_exp[e]);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        run("full", 50);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run("pre", 6);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        run("post", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
